// File: rtl/eh2_posit_pkg.sv
// Shared widths, field bundle and special encodings for the posit datapath.
// The decoder and the encoder both size their ports from these defaults.
package eh2_posit_pkg;

  localparam int POSIT_LEN   = 32;
  localparam int ES          = 3;
  localparam int REGIME_BW   = $clog2(POSIT_LEN) + 1;
  localparam int FRACTION_BW = POSIT_LEN - ES;
  localparam int TAG_BW      = 4;
  localparam int BODY_BW     = POSIT_LEN - 1;
  localparam int RUN_BW      = $clog2(POSIT_LEN);

  typedef struct packed {
    logic                        sign;
    logic signed [REGIME_BW-1:0] regime;
    logic [ES-1:0]               exponent;
    logic [FRACTION_BW-1:0]      fraction;
    logic                        is_zero;
    logic                        is_nar;
  } posit_fields_t;

  localparam logic [POSIT_LEN-1:0] POSIT_ZERO = '0;
  localparam logic [POSIT_LEN-1:0] POSIT_NAR  = {1'b1, {BODY_BW{1'b0}}};

endpackage

// File: rtl/eh2_posit_decode_if.sv
// Operand-in / fields-out handshake bundle between the operand latch, the
// posit decoder and the posit ALU.
interface eh2_posit_decode_if #(
  parameter int POSIT_LEN   = eh2_posit_pkg::POSIT_LEN,
  parameter int ES          = eh2_posit_pkg::ES,
  parameter int REGIME_BW   = eh2_posit_pkg::REGIME_BW,
  parameter int FRACTION_BW = eh2_posit_pkg::FRACTION_BW,
  parameter int TAG_BW      = eh2_posit_pkg::TAG_BW
);

  logic                        flush;
  logic                        valid_in;
  logic                        ready_out;
  logic [POSIT_LEN-1:0]        posit_in;
  logic [TAG_BW-1:0]           tag_in;
  logic                        valid_out;
  logic                        ready_in;
  logic                        sign;
  logic signed [REGIME_BW-1:0] regime;
  logic [ES-1:0]               exponent;
  logic [FRACTION_BW-1:0]      fraction;
  logic                        is_zero;
  logic                        is_nar;
  logic [TAG_BW-1:0]           tag_out;

  modport master (
    output flush, valid_in, posit_in, tag_in, ready_in,
    input  ready_out, valid_out, sign, regime, exponent, fraction,
           is_zero, is_nar, tag_out
  );

  modport slave (
    input  flush, valid_in, posit_in, tag_in, ready_in,
    output ready_out, valid_out, sign, regime, exponent, fraction,
           is_zero, is_nar, tag_out
  );

endinterface

// File: rtl/eh2_posit_lzc.sv
// Leading-run counter: number of MSB-first bits equal to ones_i before the
// first differing bit (WIDTH when the whole word matches).
module eh2_posit_lzc
  import eh2_posit_pkg::*;
#(
  parameter int WIDTH  = BODY_BW,
  parameter int CNT_BW = RUN_BW
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic              ones_i,
  output logic [CNT_BW-1:0] count_o
);

  logic [CNT_BW-1:0] cnt;
  logic              run_open;

  always_comb begin
    cnt      = '0;
    run_open = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (run_open && (data_i[i] == ones_i)) begin
        cnt = cnt + CNT_BW'(1);
      end else begin
        run_open = 1'b0;
      end
    end
  end

  assign count_o = cnt;

endmodule

// File: rtl/eh2_posit_decode.sv
// Two-stage posit decoder: S1 takes the magnitude and measures the regime run,
// S2 strips the run and splits exponent/fraction. Valid/ready on both sides.
module eh2_posit_decode #(
  parameter int POSIT_LEN   = eh2_posit_pkg::POSIT_LEN,
  parameter int ES          = eh2_posit_pkg::ES,
  parameter int REGIME_BW   = $clog2(POSIT_LEN) + 1,
  parameter int FRACTION_BW = POSIT_LEN - ES,
  parameter int TAG_BW      = eh2_posit_pkg::TAG_BW
) (
  input logic               clk,
  input logic               rst_l,
  eh2_posit_decode_if.slave io
);

  localparam int BODY_BW = POSIT_LEN - 1;
  localparam int RUN_BW  = $clog2(POSIT_LEN);
  localparam int TAIL_BW = BODY_BW - ES;

  logic                        s1_adv, s2_adv, accept;
  logic                        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

  logic [BODY_BW-1:0]          body_d;
  logic [RUN_BW-1:0]           run_d;
  logic                        zero_d, nar_d;

  logic                        s1_sign_q;
  logic [BODY_BW-1:0]          s1_body_q;
  logic [RUN_BW-1:0]           s1_run_q;
  logic                        s1_zero_q, s1_nar_q;
  logic [TAG_BW-1:0]           s1_tag_q;

  logic [RUN_BW:0]             shamt;
  logic [BODY_BW-1:0]          shifted;
  logic signed [REGIME_BW-1:0] regime_d, s2_regime_q;
  logic [ES-1:0]               exp_d, s2_exp_q;
  logic [FRACTION_BW-1:0]      frac_d, s2_frac_q;
  logic                        s2_sign_q, s2_zero_q, s2_nar_q;
  logic [TAG_BW-1:0]           s2_tag_q;

  assign s2_adv       = !s2_valid_q || io.ready_in;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign io.ready_out = s1_adv;
  assign accept       = io.valid_in && s1_adv && !io.flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (io.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s1_adv) s1_valid_d = io.valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Low bits of the negation equal the negation of the low bits, so the
  // body is formed without a full-width magnitude.
  assign body_d = io.posit_in[POSIT_LEN-1] ? -io.posit_in[BODY_BW-1:0]
                                           : io.posit_in[BODY_BW-1:0];
  assign zero_d = (io.posit_in == eh2_posit_pkg::POSIT_ZERO);
  assign nar_d  = (io.posit_in == eh2_posit_pkg::POSIT_NAR);

  eh2_posit_lzc #(
    .WIDTH  (BODY_BW),
    .CNT_BW (RUN_BW)
  ) u_lzc (
    .data_i  (body_d),
    .ones_i  (body_d[BODY_BW-1]),
    .count_o (run_d)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_sign_q <= 1'b0;
      s1_body_q <= '0;
      s1_run_q  <= '0;
      s1_zero_q <= 1'b0;
      s1_nar_q  <= 1'b0;
      s1_tag_q  <= '0;
    end else if (accept) begin
      s1_sign_q <= io.posit_in[POSIT_LEN-1];
      s1_body_q <= body_d;
      s1_run_q  <= run_d;
      s1_zero_q <= zero_d;
      s1_nar_q  <= nar_d;
      s1_tag_q  <= io.tag_in;
    end
  end

  // A full-length run shifts by BODY_BW+1, which clears everything.
  always_comb begin
    shamt    = (RUN_BW+1)'(s1_run_q) + (RUN_BW+1)'(1);
    shifted  = s1_body_q << shamt;
    regime_d = s1_body_q[BODY_BW-1] ? REGIME_BW'(s1_run_q) - REGIME_BW'(1)
                                    : REGIME_BW'(0) - REGIME_BW'(s1_run_q);
    exp_d    = shifted[BODY_BW-1 -: ES];
    frac_d   = {shifted[TAIL_BW-1:0], {(FRACTION_BW-TAIL_BW){1'b0}}};
    if (s1_zero_q || s1_nar_q) begin
      regime_d = '0;
      exp_d    = '0;
      frac_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_sign_q   <= 1'b0;
      s2_regime_q <= '0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_zero_q   <= 1'b0;
      s2_nar_q    <= 1'b0;
      s2_tag_q    <= '0;
    end else if (s2_adv && s1_valid_q && !io.flush) begin
      s2_sign_q   <= s1_sign_q;
      s2_regime_q <= regime_d;
      s2_exp_q    <= exp_d;
      s2_frac_q   <= frac_d;
      s2_zero_q   <= s1_zero_q;
      s2_nar_q    <= s1_nar_q;
      s2_tag_q    <= s1_tag_q;
    end
  end

  assign io.valid_out = s2_valid_q;
  assign io.sign      = s2_sign_q;
  assign io.regime    = s2_regime_q;
  assign io.exponent  = s2_exp_q;
  assign io.fraction  = s2_frac_q;
  assign io.is_zero   = s2_zero_q;
  assign io.is_nar    = s2_nar_q;
  assign io.tag_out   = s2_tag_q;

endmodule

// File: tb/tb_eh2_posit_decode.sv
// Bench for eh2_posit_decode: fixed decode vectors, streaming with stalls,
// flush and async reset, then random traffic against a bit-level posit model.
module tb_eh2_posit_decode;
  import eh2_posit_pkg::*;

  typedef struct {
    logic [POSIT_LEN-1:0] posit;
    posit_fields_t        exp;
  } vec_t;

  typedef struct {
    posit_fields_t     f;
    logic [TAG_BW-1:0] tag;
  } sb_entry_t;

  localparam int NVEC = 12;

  logic clk = 1'b0;
  logic rst_l;

  eh2_posit_decode_if bus ();

  eh2_posit_decode dut (
    .clk   (clk),
    .rst_l (rst_l),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          outCount = 0;
  sb_entry_t   sb[$];
  bit          prevStall = 1'b0;
  logic [63:0] snap = '0;
  vec_t        vecs[NVEC];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decode straight from the posit definition: walk the regime
  // run bit by bit, then read exponent and fraction from the leftover bits.
  function automatic posit_fields_t refDecode(input logic [POSIT_LEN-1:0] p);
    posit_fields_t        f;
    logic [POSIT_LEN-1:0] mag;
    int                   m;
    bit                   lead;
    bit                   rest[$];
    f = '0;
    if (p == POSIT_ZERO) begin
      f.is_zero = 1'b1;
      return f;
    end
    if (p == POSIT_NAR) begin
      f.is_nar = 1'b1;
      f.sign   = 1'b1;
      return f;
    end
    f.sign = p[POSIT_LEN-1];
    mag    = f.sign ? -p : p;
    lead   = mag[POSIT_LEN-2];
    m      = 0;
    while (m < POSIT_LEN - 1 && mag[POSIT_LEN-2-m] == lead) m++;
    f.regime = lead ? REGIME_BW'(m - 1) : REGIME_BW'(-m);
    for (int i = POSIT_LEN - 3 - m; i >= 0; i--) rest.push_back(mag[i]);
    while (rest.size() < ES + FRACTION_BW) rest.push_back(1'b0);
    for (int i = 0; i < ES; i++) f.exponent[ES-1-i] = rest[i];
    for (int i = 0; i < FRACTION_BW; i++) f.fraction[FRACTION_BW-1-i] = rest[ES+i];
    return f;
  endfunction

  function automatic posit_fields_t mkF(input bit s, input int k, input int e, input int fr,
                                        input bit z, input bit n);
    posit_fields_t f;
    f.sign     = s;
    f.regime   = REGIME_BW'(k);
    f.exponent = ES'(e);
    f.fraction = FRACTION_BW'(fr);
    f.is_zero  = z;
    f.is_nar   = n;
    return f;
  endfunction

  function automatic posit_fields_t packActual();
    posit_fields_t f;
    f.sign     = bus.sign;
    f.regime   = bus.regime;
    f.exponent = bus.exponent;
    f.fraction = bus.fraction;
    f.is_zero  = bus.is_zero;
    f.is_nar   = bus.is_nar;
    return f;
  endfunction

  function automatic logic [POSIT_LEN-1:0] randPosit();
    logic [POSIT_LEN-1:0] p;
    case ($urandom_range(0, 5))
      0, 1: p = 32'($urandom);
      2:    p = 32'($urandom) >> $urandom_range(0, 31);
      3:    p = ~(32'($urandom) >> $urandom_range(0, 31));
      4:    p = {1'b0, 31'h7FFFFFFF ^ (31'($urandom) >> $urandom_range(0, 30))};
      default: begin
        case ($urandom_range(0, 5))
          0:       p = POSIT_ZERO;
          1:       p = POSIT_NAR;
          2:       p = 32'h7FFFFFFF;
          3:       p = 32'h00000001;
          4:       p = 32'hFFFFFFFF;
          default: p = 32'h80000001;
        endcase
      end
    endcase
    return p;
  endfunction

  // One cycle: drive inputs, check at the falling edge against the
  // scoreboard, then advance to just after the next rising edge.
  task automatic applyStimulus(input bit vIn, input logic [POSIT_LEN-1:0] p,
                               input logic [TAG_BW-1:0] t, input bit rdy, input bit fl,
                               output bit took);
    sb_entry_t e;
    bus.valid_in = vIn;
    bus.posit_in = p;
    bus.tag_in   = t;
    bus.ready_in = rdy;
    bus.flush    = fl;
    @(negedge clk);
    checkOutput("ready_out", 64'(bus.ready_out), 64'(!(sb.size() == 2 && !rdy)));
    if (prevStall)
      checkOutput("stall_hold", 64'({bus.valid_out, bus.tag_out, packActual()}), snap);
    if (sb.size() == 0)
      checkOutput("idle_valid", 64'(bus.valid_out), 64'(0));
    else if (bus.valid_out && rdy) begin
      e = sb.pop_front();
      checkOutput("fields", 64'(packActual()), 64'(e.f));
      checkOutput("tag", 64'(bus.tag_out), 64'(e.tag));
      outCount++;
    end
    took = vIn && bus.ready_out && !fl;
    if (fl) sb.delete();
    if (took) begin
      e.f   = refDecode(p);
      e.tag = t;
      sb.push_back(e);
    end
    prevStall = bus.valid_out && !rdy && !fl;
    snap      = 64'({bus.valid_out, bus.tag_out, packActual()});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit took;
    int idx, cyc, base;

    vecs[0]  = '{32'h40000000, mkF(0,   0, 0, 0,           0, 0)};
    vecs[1]  = '{32'h48000000, mkF(0,   0, 2, 0,           0, 0)};
    vecs[2]  = '{32'h40100000, mkF(0,   0, 0, 32'h00800000, 0, 0)};
    vecs[3]  = '{32'hC0000000, mkF(1,   0, 0, 0,           0, 0)};
    vecs[4]  = '{32'h7FFFFFFF, mkF(0,  30, 0, 0,           0, 0)};
    vecs[5]  = '{32'h7FFFFFFE, mkF(0,  29, 0, 0,           0, 0)};
    vecs[6]  = '{32'h00000001, mkF(0, -30, 0, 0,           0, 0)};
    vecs[7]  = '{32'h00000000, mkF(0,   0, 0, 0,           1, 0)};
    vecs[8]  = '{32'h80000000, mkF(1,   0, 0, 0,           0, 1)};
    vecs[9]  = '{32'h3FFFFFFF, mkF(0,  -1, 7, 32'h1FFFFFF8, 0, 0)};
    vecs[10] = '{32'hFFFFFFFF, mkF(1, -30, 0, 0,           0, 0)};
    vecs[11] = '{32'h5A5A5A5A, mkF(0,   0, 6, 32'h12D2D2D0, 0, 0)};

    rst_l        = 1'b0;
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    bus.posit_in = '0;
    bus.tag_in   = '0;
    bus.ready_in = 1'b0;
    #2;
    checkOutput("reset_outputs", 64'({bus.valid_out, bus.tag_out, packActual()}), 64'(0));
    checkOutput("reset_ready", 64'(bus.ready_out), 64'(1));
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    $display("[TB] fixed decode vectors");
    for (int i = 0; i < NVEC; i++) begin
      bus.valid_in = 1'b1;
      bus.posit_in = vecs[i].posit;
      bus.tag_in   = 4'(i);
      bus.ready_in = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      checkOutput($sformatf("vec%0d_lat1", i), 64'(bus.valid_out), 64'(0));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_lat2", i), 64'(bus.valid_out), 64'(1));
      checkOutput($sformatf("vec%0d_fields", i), 64'(packActual()), 64'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_tag", i), 64'(bus.tag_out), 64'(i));
      @(posedge clk);
      #1;
    end

    $display("[TB] eight-entry stream with mid-stream stall");
    idx = 0;
    cyc = 0;
    outCount = 0;
    while ((idx < 8 || sb.size() != 0) && cyc < 40) begin
      applyStimulus(idx < 8, randPosit(), 4'(idx), !(cyc >= 3 && cyc < 6), 1'b0, took);
      if (took) idx++;
      cyc++;
    end
    checkOutput("stream_count", 64'(outCount), 64'(8));

    $display("[TB] flush with two entries in flight");
    applyStimulus(1'b1, 32'h40100000, 4'hA, 1'b1, 1'b0, took);
    applyStimulus(1'b1, 32'h7FFFFFFE, 4'hB, 1'b1, 1'b0, took);
    applyStimulus(1'b1, 32'hC0000000, 4'hC, 1'b0, 1'b1, took);
    checkOutput("flush_valid_out", 64'(bus.valid_out), 64'(0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, took);
    base = outCount;
    applyStimulus(1'b1, 32'h48000000, 4'hD, 1'b1, 1'b0, took);
    cyc = 0;
    while (sb.size() != 0 && cyc < 10) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, took);
      cyc++;
    end
    checkOutput("post_flush_count", 64'(outCount - base), 64'(1));

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randPosit(), 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, took);
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, took);
      cyc++;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'(0));

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 32'h48000000, 4'h3, 1'b1, 1'b0, took);
    applyStimulus(1'b1, 32'h3FFFFFFF, 4'h4, 1'b1, 1'b0, took);
    bus.valid_in = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("midreset_outputs", 64'({bus.valid_out, bus.tag_out, packActual()}), 64'(0));
    checkOutput("midreset_ready", 64'(bus.ready_out), 64'(1));
    sb.delete();
    prevStall = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, took);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
